sum_display_mux: RTL
====================

Name: sum_display_mux

Overview:
Downstream consumer of the 4-bit ripple-carry adder. It captures the adder result {co, zi} (0..31) on a load strobe and converts it to two BCD digits with a sequential double-dabble engine. It then drives a time-multiplexed two-digit 7-segment display on the lab board.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit is held before switching; minimum 2; counter width is $clog2(REFRESH_DIV).
ACTIVE_LOW, 1, 1 = seg and an outputs are active-low (board default); 0 = active-high.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset.
ld  input  1  load strobe; sampled only while rdy=1.
co  input  1  adder carry-out; bit 4 of the value.
zi  input  4  adder sum; bits 3:0 of the value.
rdy  output  1  1 = idle and ready to accept ld.
seg  output  7  segments {g,f,e,d,c,b,a}.
an  output  2  digit enables; an[0] = units, an[1] = tens.

Behaviour:
Reset (rst=0, asynchronous):
- FSM to IDLE; rdy=1.
- Display registers tens=0, units=0.
- Refresh counter=0; digit select = units.
- Result while held in reset with ACTIVE_LOW=1: an=2'b10, seg=7'h40 (units shows "0", tens slot selected off).

Load / conversion FSM (states IDLE, CONV):
- IDLE: ld=1 at edge N:
  - bin <= {co,zi}, bcd <= 0, cnt <= 0, state <= CONV, rdy <= 0.
  - ld=0 holds IDLE.
- CONV: each edge performs one double-dabble step:
  - Add 3 to each BCD nibble that is >=5.
  - Then shift {bcd,bin} left by 1.
  - cnt++.
- Fifth step lands at edge N+5. On that same edge:
  - Commit tens <= bcd[7:4] (0..3), units <= bcd[3:0] (0..9).
  - state <= IDLE, rdy <= 1.
- rdy is low for exactly 5 cycles. Latency from ld edge to displayed value is 5 clk.
- ld while rdy=0 is ignored; no queuing.
- Inputs co and zi are sampled only at the accepting edge.
- Display registers keep the previous value until commit; there is no intermediate value on seg.
- Reset mid-conversion aborts: display goes to 0, rdy=1.

Refresh:
- Counter runs freely 0..REFRESH_DIV-1.
- On wrap to 0, digit select toggles.
- Each digit is shown for exactly REFRESH_DIV cycles.
- The counter is independent of the FSM; loads do not reset it.

Output decode (combinational from registers only, never from inputs):
- Active-high patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Leading-zero blanking: tens slot selected and tens=0 -> all segments off. an still asserts the tens digit.
- Units digit is never blanked.
- ACTIVE_LOW=1 inverts both seg and an.

Test Plan:
- Reset: assert rst=0 mid-run -> immediately rdy=1, an=2'b10, seg=7'h40; after release the tens slot shows seg=7'h7F (blank).
- Max value: co=1, zi=4'hF, ld pulse -> rdy=0 for 5 cycles, then tens=3, units=1; units slot seg=7'h79, tens slot (an=2'b01) seg=7'h30.
- Single digit: co=0, zi=9 -> units slot seg=7'h10, tens slot seg=7'h7F (blanked).
- Carry only: co=1, zi=0 (16) -> tens slot seg=7'h79, units slot seg=7'h02.
- Busy ignore: load 31, then ld with value 5 on the next cycle -> display shows 31 and rdy returns high at N+5 only once. Reset asserted at cycle N+3 of a conversion -> display 0, rdy=1.
- Refresh: REFRESH_DIV=4 in sim -> an alternates 2'b10/2'b01 every 4 clk, unaffected by ld activity. Check ACTIVE_LOW=0 build gives an=2'b01 and seg=7'h3F after reset.

Source files
------------

// File: rtl/sum_display_mux_if.sv
// Adder-result load port and multiplexed 7-segment display lines of sum_display_mux.
// The master side drives the load strobe and value; the slave side returns ready and display.
interface sum_display_mux_if;
  logic       ld;
  logic       co;
  logic [3:0] zi;
  logic       rdy;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (output ld, co, zi, input rdy, seg, an);
  modport slave  (input ld, co, zi, output rdy, seg, an);
endinterface

// File: rtl/sum_display_mux.sv
// Captures the 5-bit adder result, converts it to BCD with a sequential double-dabble,
// and drives a time-multiplexed two-digit 7-segment display with leading-zero blanking.
module sum_display_mux #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input logic              clk,
  input logic              rst,
  sum_display_mux_if.slave bus
);

  localparam int unsigned      CNT_W        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       LAST_STEP    = 3'd4;

  typedef enum logic {IDLE, CONV} state_e;
  typedef enum logic {DIG_UNITS, DIG_TENS} digit_e;

  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [4:0]       bin_q, bin_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [2:0]       step_q, step_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  digit_e           sel_q, sel_d;

  logic [7:0]  bcd_adj;
  logic [12:0] dd_shift;
  logic [3:0]  shown_digit;
  logic [6:0]  seg_on;
  logic [1:0]  an_on;

  function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
    state_d   = state_q;
    rdy_d     = rdy_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    step_d    = step_q;
    tens_d    = tens_q;
    units_d   = units_q;
    refresh_d = refresh_q;
    sel_d     = sel_q;

    bcd_adj  = {dabble_adjust(bcd_q[7:4]), dabble_adjust(bcd_q[3:0])};
    dd_shift = {bcd_adj, bin_q} << 1;

    case (state_q)
      IDLE: begin
        if (bus.ld) begin
          bin_d   = {bus.co, bus.zi};
          bcd_d   = '0;
          step_d  = '0;
          state_d = CONV;
          rdy_d   = 1'b0;
        end
      end
      CONV: begin
        bcd_d  = dd_shift[12:5];
        bin_d  = dd_shift[4:0];
        step_d = step_q + 3'd1;
        // The fifth shift completes the conversion; commit its result on the same edge.
        if (step_q == LAST_STEP) begin
          tens_d  = dd_shift[12:9];
          units_d = dd_shift[8:5];
          state_d = IDLE;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase

    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      sel_d     = (sel_q == DIG_TENS) ? DIG_UNITS : DIG_TENS;
    end else begin
      refresh_d = refresh_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop updates from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b1;
      bin_q     <= '0;
      bcd_q     <= '0;
      step_q    <= '0;
      tens_q    <= '0;
      units_q   <= '0;
      refresh_q <= '0;
      sel_q     <= DIG_UNITS;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      step_q    <= step_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
    end
  end

  // Display decode reads only registers, so input activity never glitches the segments.
  always_comb begin
    shown_digit = (sel_q == DIG_TENS) ? tens_q : units_q;
    seg_on      = seg_pattern(shown_digit);
    if ((sel_q == DIG_TENS) && (tens_q == 4'd0)) begin
      seg_on = '0;
    end
    an_on = (sel_q == DIG_TENS) ? 2'b10 : 2'b01;
  end

  assign bus.rdy = rdy_q;
  assign bus.seg = ACTIVE_LOW ? ~seg_on : seg_on;
  assign bus.an  = ACTIVE_LOW ? ~an_on : an_on;

endmodule
